seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter A_WIDTH, default 2: multiplicand width in bits, legal range 1..16.
REQ-002 Parameter B_WIDTH, default 3: multiplier width in bits, legal range 1..16; also the number of add/shift iterations.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port start, input, 1: request to begin a multiplication.
REQ-006 Port a, input, A_WIDTH: multiplicand, unsigned, sampled only on the accepting edge.
REQ-007 Port b, input, B_WIDTH: multiplier, unsigned, sampled only on the accepting edge.
REQ-008 Port busy, output, 1: high while the state is RUN.
REQ-009 Port done, output, 1: one-cycle pulse, high while the state is DONE.
REQ-010 Port product, output, A_WIDTH+B_WIDTH: unsigned result register.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-012 The block SHALL accept start only in IDLE or DONE; on the accepting edge it latches a and b, clears product to 0, clears the iteration counter cnt to 0, and enters RUN.
REQ-013 In RUN, on each edge, if b_reg[cnt]=1 the block SHALL add (a_reg << cnt) to product, otherwise hold product; it SHALL then increment cnt.
REQ-014 On the RUN edge where cnt = B_WIDTH-1, the FSM SHALL enter DONE.
REQ-015 Latency: done SHALL be high exactly B_WIDTH+1 rising edges after the accepting edge (the accepting edge counts as edge 0) and SHALL stay high for one cycle.
REQ-016 From DONE with start=0, the FSM SHALL return to IDLE; from DONE with start=1, it SHALL begin a new operation per REQ-012 (back-to-back, no idle cycle).
REQ-017 start in RUN SHALL be ignored; a, b and product SHALL be unaffected.
REQ-018 product SHALL equal a_reg*b_reg exactly when done is high, with no truncation at the A_WIDTH+B_WIDTH width, and SHALL hold that value until the next accepting edge or reset.
REQ-019 Changes on a and b outside the accepting edge SHALL have no effect.
REQ-020 B_WIDTH=1 SHALL be supported: one RUN cycle, then DONE.

Reset
REQ-021 While rst_n=0 at a rising edge, the block SHALL set the state to IDLE and set busy=0, done=0, product=0, cnt=0, a_reg=0 and b_reg=0.
REQ-022 Reset mid-RUN or in DONE SHALL abort the operation; done SHALL NOT pulse for the aborted operation.
REQ-023 In the first cycle after reset is released, a start SHALL be accepted.

Structure
REQ-024 A shared package mult_pkg SHALL hold the state enum (IDLE/RUN/DONE) and a product-width constant function.
REQ-025 Addition SHALL be performed by one sub-module, ripple_adder (parameter WIDTH; ports a, b, cin, sum, cout), built as a chain of the team's 1-bit full-adder cells with cin tied to 0.
REQ-026 The counter width SHALL be $clog2(B_WIDTH)+1 bits.

Verification
REQ-027 Defaults, a=3, b=7, start pulse: busy high 3 cycles, done at edge 4, product=21.
REQ-028 Defaults, a=0, b=5, then a=3, b=0: product=0 with done on schedule in both cases.
REQ-029 Defaults, a=2, b=5, start re-asserted during RUN with a=3: ignored; product=10.
REQ-030 Defaults, a=3, b=7, rst_n low at the second RUN edge: state IDLE, product=0, no done pulse; a following operation with a=1, b=1 gives product=1.
REQ-031 Defaults, start held high through DONE with a=2, b=3: second operation starts immediately; product=6 at the next done.
REQ-032 A_WIDTH=4, B_WIDTH=4, a=15, b=15: done at edge 5, product=225; B_WIDTH=1, a=3, b=1: done at edge 2, product=3.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Full-precision product width: never truncates a_width x b_width.
   function automatic int prod_width(input int aw, input int bw);
      return aw + bw;
   endfunction

endpackage

// File: rtl/full_adder.sv
// 1-bit full-adder cell, the building block of the ripple adder.
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic sum_o,
   output logic cout_o
);

   assign sum_o  = a_i ^ b_i ^ cin_i;
   assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/ripple_adder.sv
// WIDTH-bit ripple-carry adder made of chained full-adder cells.
module ripple_adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] carry;

   assign carry[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      full_adder u_fa (
         .a_i   (a[i]),
         .b_i   (b[i]),
         .cin_i (carry[i]),
         .sum_o (sum[i]),
         .cout_o(carry[i+1])
      );
   end

   assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier: one multiplier bit per cycle,
// B_WIDTH RUN cycles, then a one-cycle DONE with the full-width product.
module seq_multiplier
   import mult_pkg::*;
#(
   parameter int A_WIDTH = 2,
   parameter int B_WIDTH = 3
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     start,
   input  logic [A_WIDTH-1:0]                       a,
   input  logic [B_WIDTH-1:0]                       b,
   output logic                                     busy,
   output logic                                     done,
   output logic [prod_width(A_WIDTH, B_WIDTH)-1:0]  product
);

   localparam int            P    = prod_width(A_WIDTH, B_WIDTH);
   localparam int            CW   = $clog2(B_WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(B_WIDTH - 1);

   state_e               state_q;
   logic [A_WIDTH-1:0]   a_q;
   logic [B_WIDTH-1:0]   b_q;
   logic [P-1:0]         prod_q;
   logic [CW-1:0]        cnt_q;
   logic                 busy_q;
   logic                 done_q;

   logic                 b_bit;
   logic [P-1:0]         addend;
   logic [P-1:0]         prod_d;
   logic                 add_cout_unused;

   // Pick the multiplier bit for the current iteration (explicit mux keeps
   // the counter width independent of the index width).
   always_comb begin
      b_bit = 1'b0;
      for (int i = 0; i < B_WIDTH; i++) begin
         if (cnt_q == CW'(i)) b_bit = b_q[i];
      end
   end

   // Partial product: a shifted into position, or zero so the add holds.
   assign addend = b_bit ? (P'(a_q) << cnt_q) : '0;

   // The product register is P bits and a*b < 2^P, so the carry-out is
   // always zero.
   ripple_adder #(.WIDTH(P)) u_add (
      .a   (prod_q),
      .b   (addend),
      .cin (1'b0),
      .sum (prod_d),
      .cout(add_cout_unused)
   );

   // Control FSM and datapath registers; busy/done are registered with state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  prod_q  <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               prod_q <= prod_d;
               cnt_q  <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = prod_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: default, 4x4 and B_WIDTH=1 instances.
module tb_seq_multiplier;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int prod;
      int due;
   } exp_t;

   exp_t q0[$], q1[$], q2[$];
   exp_t e0, e1, e2;

   logic       rst_n;
   // default instance (A=2, B=3)
   logic       st0, busy0, done0;
   logic [1:0] a0;
   logic [2:0] b0;
   logic [4:0] p0;
   // 4x4 instance
   logic       st1, busy1, done1;
   logic [3:0] a1, b1;
   logic [7:0] p1;
   // A=2, B=1 instance
   logic       st2, busy2, done2;
   logic [1:0] a2;
   logic [0:0] b2;
   logic [2:0] p2;

   seq_multiplier dut0 (
      .clk(clk), .rst_n(rst_n), .start(st0), .a(a0), .b(b0),
      .busy(busy0), .done(done0), .product(p0)
   );

   seq_multiplier #(.A_WIDTH(4), .B_WIDTH(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .product(p1)
   );

   seq_multiplier #(.A_WIDTH(2), .B_WIDTH(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .product(p2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitors: every done pulse must match the oldest expectation in value
   // and in the cycle it was due.
   always @(negedge clk) begin
      if (done0 === 1'b1) begin
         if (q0.size() == 0) chk("d0_unexpected_done", 1, 0);
         else begin
            e0 = q0.pop_front();
            chk("d0_product", 32'(p0), e0.prod);
            chk("d0_latency", cyc, e0.due);
         end
      end
   end

   always @(negedge clk) begin
      if (done1 === 1'b1) begin
         if (q1.size() == 0) chk("d1_unexpected_done", 1, 0);
         else begin
            e1 = q1.pop_front();
            chk("d1_product", 32'(p1), e1.prod);
            chk("d1_latency", cyc, e1.due);
         end
      end
   end

   always @(negedge clk) begin
      if (done2 === 1'b1) begin
         if (q2.size() == 0) chk("d2_unexpected_done", 1, 0);
         else begin
            e2 = q2.pop_front();
            chk("d2_product", 32'(p2), e2.prod);
            chk("d2_latency", cyc, e2.due);
         end
      end
   end

   // Single start pulse on the default instance, scrambling a/b during RUN,
   // checking busy for 3 cycles and the product hold afterwards.
   task automatic op0(input logic [1:0] a, input logic [2:0] b, input int expp);
      @(negedge clk);
      st0 = 1'b1; a0 = a; b0 = b;
      @(posedge clk); #1;
      q0.push_back('{expp, cyc + 3});
      @(negedge clk);
      st0 = 1'b0; a0 = ~a; b0 = ~b;
      for (int i = 0; i < 3; i++) begin
         chk("d0_busy_run", 32'(busy0), 1);
         @(negedge clk);
      end
      chk("d0_busy_done", 32'(busy0), 0);
      @(negedge clk);
      chk("d0_hold", 32'(p0), expp);
      chk("d0_done_once", 32'(done0), 0);
   endtask

   task automatic op1(input logic [3:0] a, input logic [3:0] b, input int expp);
      @(negedge clk);
      st1 = 1'b1; a1 = a; b1 = b;
      @(posedge clk); #1;
      q1.push_back('{expp, cyc + 4});
      @(negedge clk);
      st1 = 1'b0; a1 = 4'd0; b1 = 4'd0;
      repeat (6) @(negedge clk);
      chk("d1_hold", 32'(p1), expp);
   endtask

   task automatic op2(input logic [1:0] a, input logic b, input int expp);
      @(negedge clk);
      st2 = 1'b1; a2 = a; b2 = b;
      @(posedge clk); #1;
      q2.push_back('{expp, cyc + 1});
      @(negedge clk);
      st2 = 1'b0; a2 = 2'd0; b2 = ~b;
      chk("d2_busy_run", 32'(busy2), 1);
      repeat (3) @(negedge clk);
      chk("d2_hold", 32'(p2), expp);
   endtask

   initial begin
      rst_n = 1'b0;
      st0 = 1'b0; a0 = '0; b0 = '0;
      st1 = 1'b0; a1 = '0; b1 = '0;
      st2 = 1'b0; a2 = '0; b2 = '0;
      repeat (3) @(negedge clk);
      chk("rst_product0", 32'(p0), 0);
      chk("rst_busy0", 32'(busy0), 0);
      chk("rst_done0", 32'(done0), 0);
      chk("rst_product1", 32'(p1), 0);
      chk("rst_product2", 32'(p2), 0);
      rst_n = 1'b1;

      // basic products, including zero operands
      op0(2'd3, 3'd7, 21);
      op0(2'd0, 3'd5, 0);
      op0(2'd3, 3'd0, 0);

      // start re-asserted during RUN with a different a is ignored
      @(negedge clk);
      st0 = 1'b1; a0 = 2'd2; b0 = 3'd5;
      @(posedge clk); #1;
      q0.push_back('{10, cyc + 3});
      @(negedge clk);
      st0 = 1'b1; a0 = 2'd3;
      @(negedge clk);
      st0 = 1'b0;
      repeat (3) @(negedge clk);
      chk("d0_ignore_start", 32'(p0), 10);

      // reset at the second RUN edge aborts; start accepted right after
      @(negedge clk);
      st0 = 1'b1; a0 = 2'd3; b0 = 3'd7;
      @(posedge clk); #1;
      @(negedge clk);
      st0 = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_busy", 32'(busy0), 0);
      chk("abort_done", 32'(done0), 0);
      chk("abort_product", 32'(p0), 0);
      st0 = 1'b1; a0 = 2'd1; b0 = 3'd1;
      @(posedge clk); #1;
      q0.push_back('{1, cyc + 3});
      @(negedge clk);
      st0 = 1'b0;
      repeat (4) @(negedge clk);
      chk("after_abort_product", 32'(p0), 1);

      // start held through DONE: back-to-back operation picks up new a/b
      @(negedge clk);
      st0 = 1'b1; a0 = 2'd3; b0 = 3'd5;
      @(posedge clk); #1;
      q0.push_back('{15, cyc + 3});
      @(negedge clk);
      a0 = 2'd2; b0 = 3'd3;
      repeat (4) @(posedge clk);
      #1;
      q0.push_back('{6, cyc + 3});
      @(negedge clk);
      st0 = 1'b0;
      repeat (5) @(negedge clk);
      chk("b2b_product", 32'(p0), 6);

      // wider instance and single-iteration instance
      op1(4'd15, 4'd15, 225);
      op1(4'd9, 4'd13, 117);
      op2(2'd3, 1'b1, 3);
      op2(2'd2, 1'b0, 0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(q0.size() + q1.size() + q2.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
